// File: rtl/lcd_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lcd_timing_ctrl
// Purpose  : Dot/line sequencer producing LY, PPU mode, STAT/VBlank pulses,
//            renderer start pulses and VRAM/OAM CPU-access locks.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_timing_ctrl #(
    parameter int DOTS_PER_LINE = 456,
    parameter int OAM_DOTS      = 80,
    parameter int XFER_DOTS     = 172,
    parameter int VISIBLE_LINES = 144,
    parameter int TOTAL_LINES   = 154
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dot_en,
    input  logic       lcd_on,
    input  logic [7:0] lyc,
    input  logic [3:0] stat_sel,
    output logic [7:0] ly,
    output logic [1:0] mode,
    output logic       coincidence,
    output logic       drawline,
    output logic       frame_start,
    output logic       vblank_irq,
    output logic       stat_irq,
    output logic       vram_locked,
    output logic       oam_locked
);

    localparam logic [1:0] c_mode_hblank = 2'd0;
    localparam logic [1:0] c_mode_vblank = 2'd1;
    localparam logic [1:0] c_mode_oam    = 2'd2;
    localparam logic [1:0] c_mode_xfer   = 2'd3;

    localparam logic [8:0] c_dot_last = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] c_oam_end  = 9'(OAM_DOTS);
    localparam logic [8:0] c_xfer_end = 9'(OAM_DOTS + XFER_DOTS);
    localparam logic [7:0] c_ly_vis   = 8'(VISIBLE_LINES);
    localparam logic [7:0] c_ly_last  = 8'(TOTAL_LINES - 1);

    logic [8:0] r_dot;
    logic       r_running;
    logic       r_stat_line;

    logic       w_advance;
    logic       w_active;
    logic [8:0] w_dot_nxt;
    logic [7:0] w_ly_nxt;
    logic [1:0] w_mode_nxt;
    logic       w_coin_nxt;
    logic       w_stat_line_nxt;

    assign w_advance = lcd_on & dot_en;
    assign w_active  = r_running | w_advance;

    // The first dot_en after reset or LCD enable parks the counters at (0,0)
    // instead of advancing, so line 0 gets its full OAM period.
    always_comb begin
        w_dot_nxt = r_dot;
        w_ly_nxt  = ly;
        if (w_advance) begin
            if (!r_running) begin
                w_dot_nxt = 9'd0;
                w_ly_nxt  = 8'd0;
            end else if (r_dot == c_dot_last) begin
                w_dot_nxt = 9'd0;
                w_ly_nxt  = (ly == c_ly_last) ? 8'd0 : ly + 8'd1;
            end else begin
                w_dot_nxt = r_dot + 9'd1;
            end
        end
    end

    always_comb begin
        w_mode_nxt = c_mode_hblank;
        if (w_active) begin
            if (w_ly_nxt >= c_ly_vis)        w_mode_nxt = c_mode_vblank;
            else if (w_dot_nxt < c_oam_end)  w_mode_nxt = c_mode_oam;
            else if (w_dot_nxt < c_xfer_end) w_mode_nxt = c_mode_xfer;
            else                             w_mode_nxt = c_mode_hblank;
        end
    end

    assign w_coin_nxt      = (w_ly_nxt == lyc);
    assign w_stat_line_nxt = (stat_sel[3] & w_coin_nxt)
                           | (stat_sel[2] & (w_mode_nxt == c_mode_oam))
                           | (stat_sel[1] & (w_mode_nxt == c_mode_vblank))
                           | (stat_sel[0] & (w_mode_nxt == c_mode_hblank));

    always_ff @(posedge clk) begin
        if (reset || !lcd_on) begin
            r_dot       <= 9'd0;
            ly          <= 8'd0;
            mode        <= c_mode_hblank;
            coincidence <= (lyc == 8'd0);
            drawline    <= 1'b0;
            frame_start <= 1'b0;
            vblank_irq  <= 1'b0;
            stat_irq    <= 1'b0;
            vram_locked <= 1'b0;
            oam_locked  <= 1'b0;
            r_stat_line <= 1'b0;
            r_running   <= 1'b0;
        end else begin
            r_dot       <= w_dot_nxt;
            ly          <= w_ly_nxt;
            mode        <= w_mode_nxt;
            coincidence <= w_coin_nxt;
            drawline    <= w_advance & (w_dot_nxt == c_oam_end) & (w_ly_nxt < c_ly_vis);
            frame_start <= w_advance & (w_dot_nxt == 9'd0) & (w_ly_nxt == 8'd0);
            vblank_irq  <= w_advance & (w_dot_nxt == 9'd0) & (w_ly_nxt == c_ly_vis);
            stat_irq    <= w_stat_line_nxt & ~r_stat_line;
            vram_locked <= (w_mode_nxt == c_mode_xfer);
            oam_locked  <= (w_mode_nxt == c_mode_xfer) | (w_mode_nxt == c_mode_oam);
            r_stat_line <= w_stat_line_nxt;
            r_running   <= r_running | dot_en;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_timing_ctrl
// Purpose  : Directed self-checking bench for lcd_timing_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_timing_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       dot_en = 1'b0;
    logic       lcd_on = 1'b1;
    logic [7:0] lyc = 8'd0;
    logic [3:0] stat_sel = 4'd0;
    logic [7:0] ly;
    logic [1:0] mode;
    logic       coincidence, drawline, frame_start, vblank_irq, stat_irq;
    logic       vram_locked, oam_locked;

    int checks = 0;
    int errors = 0;

    // Reference position and per-cycle tallies
    int    d, l;
    bit    started;
    bit    prev_line;
    int    bad;
    string first_bad;
    int    n_draw, n_vb, n_fs, n_m1;
    int    vb_l, vb_d, vb_mode;

    lcd_timing_ctrl dut (
        .clk(clk), .reset(reset), .dot_en(dot_en), .lcd_on(lcd_on),
        .lyc(lyc), .stat_sel(stat_sel), .ly(ly), .mode(mode),
        .coincidence(coincidence), .drawline(drawline),
        .frame_start(frame_start), .vblank_irq(vblank_irq),
        .stat_irq(stat_irq), .vram_locked(vram_locked), .oam_locked(oam_locked)
    );

    always #5 clk = ~clk;

    task automatic model_cmp(input bit adv);
        logic [1:0] e_mode;
        bit e_coin, e_line, e_irq, e_draw, e_fs, e_vb;
        logic [15:0] exp_v, got_v;
        e_mode = (l >= 144) ? 2'd1 : (d < 80) ? 2'd2 : (d < 252) ? 2'd3 : 2'd0;
        e_coin = (l == int'(lyc));
        e_line = (stat_sel[3] & e_coin) | (stat_sel[2] & (e_mode == 2'd2))
               | (stat_sel[1] & (e_mode == 2'd1)) | (stat_sel[0] & (e_mode == 2'd0));
        e_irq  = e_line & ~prev_line;
        prev_line = e_line;
        e_draw = adv && d == 80 && l < 144;
        e_fs   = adv && d == 0 && l == 0;
        e_vb   = adv && d == 0 && l == 144;
        exp_v = {8'(l), e_mode, e_coin, e_draw, e_fs, e_vb, e_irq, e_mode == 2'd3,
                 (e_mode == 2'd2) || (e_mode == 2'd3)};
        got_v = {ly, mode, coincidence, drawline, frame_start, vblank_irq, stat_irq,
                 vram_locked, oam_locked};
        if (got_v !== exp_v) begin
            if (bad == 0)
                first_bad = $sformatf("ly%0d dot%0d got %h want %h", l, d, got_v, exp_v);
            bad++;
        end
        n_draw += int'(drawline);
        n_vb   += int'(vblank_irq);
        n_fs   += int'(frame_start);
        n_m1   += int'(mode == 2'd1);
        if (vblank_irq) begin
            vb_l = int'(ly); vb_d = d; vb_mode = int'(mode);
        end
    endtask

    task automatic step();
        dot_en = 1'b1;
        @(posedge clk); #1;
        if (!started) begin
            started = 1'b1; d = 0; l = 0;
        end else if (d == 455) begin
            d = 0;
            l = (l == 153) ? 0 : l + 1;
        end else begin
            d++;
        end
        model_cmp(1'b1);
    endtask

    task automatic idle();
        dot_en = 1'b0;
        @(posedge clk); #1;
        model_cmp(1'b0);
    endtask

    task automatic check_bad(input string name);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL %s model_track got %0d bad cycles want 0 (first: %s)", name, bad, first_bad);
        end
        bad = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1; lcd_on = 1'b1; dot_en = 1'b1; lyc = 8'd0; stat_sel = 4'd0;
        repeat (3) @(posedge clk); #1;
        checks++; if (ly !== 8'd0) begin errors++; $display("FAIL reset_ly got %0d want 0", ly); end
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL reset_mode got %0d want 0", mode); end
        checks++; if (coincidence !== 1'b1) begin errors++; $display("FAIL reset_coin got %b want 1", coincidence); end
        checks++;
        if ({drawline, frame_start, vblank_irq, stat_irq, vram_locked, oam_locked} !== 6'd0) begin
            errors++;
            $display("FAIL reset_pulses_locks got %b want 000000",
                     {drawline, frame_start, vblank_irq, stat_irq, vram_locked, oam_locked});
        end
        lyc = 8'd7;
        @(posedge clk); #1;
        checks++; if (coincidence !== 1'b0) begin errors++; $display("FAIL reset_coin_lyc7 got %b want 0", coincidence); end
        reset = 1'b0; dot_en = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (mode !== 2'd0 || frame_start !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset got mode %0d fs %b want mode 0 fs 0", mode, frame_start);
        end
    endtask

    task automatic test_first_line();
        int m0, m2, m3, fs0, draw_dot;
        m0 = 0; m2 = 0; m3 = 0; draw_dot = -1;
        stat_sel = 4'b1001; lyc = 8'd5;
        started = 1'b0; prev_line = 1'b0; bad = 0;
        n_draw = 0; n_vb = 0; n_fs = 0; n_m1 = 0;
        step();
        fs0 = int'(frame_start);
        for (int i = 0; i < 456; i++) begin
            if (i > 0) step();
            if (mode == 2'd0) m0++;
            if (mode == 2'd2) m2++;
            if (mode == 2'd3) m3++;
            if (drawline) draw_dot = d;
        end
        checks++; if (fs0 !== 1) begin errors++; $display("FAIL start_frame_start got %0d want 1", fs0); end
        checks++; if (m2 !== 80) begin errors++; $display("FAIL mode2_len got %0d want 80", m2); end
        checks++; if (m3 !== 172) begin errors++; $display("FAIL mode3_len got %0d want 172", m3); end
        checks++; if (m0 !== 204) begin errors++; $display("FAIL mode0_len got %0d want 204", m0); end
        checks++; if (n_draw !== 1 || draw_dot !== 80) begin
            errors++; $display("FAIL line0_drawline got %0d pulses at dot %0d want 1 at 80", n_draw, draw_dot);
        end
        step();
        checks++; if (ly !== 8'd1 || mode !== 2'd2) begin
            errors++; $display("FAIL line_wrap got ly %0d mode %0d want ly 1 mode 2", ly, mode);
        end
        check_bad("first_line");
    endtask

    task automatic test_stat_blocking();
        int irq4_dot, irq5, coin5;
        irq4_dot = -1; irq5 = 0; coin5 = 0;
        for (int g = 0; g < 5000 && !(l == 6 && d == 0); g++) begin
            step();
            if (stat_irq && l == 4) irq4_dot = d;
            if (stat_irq && l == 5) irq5++;
            if (l == 5 && d == 0) coin5 = int'(coincidence);
        end
        checks++; if (irq4_dot !== 252) begin errors++; $display("FAIL hblank4_irq got dot %0d want 252", irq4_dot); end
        checks++; if (irq5 !== 0) begin errors++; $display("FAIL blocked_line5_irq got %0d want 0", irq5); end
        checks++; if (coin5 !== 1) begin errors++; $display("FAIL coin_line5 got %0d want 1", coin5); end
        check_bad("stat_blocking");
    endtask

    task automatic test_lyc_coincidence();
        int coin_cnt, irq_cnt, irq_l, irq_d;
        coin_cnt = 0; irq_cnt = 0; irq_l = -1; irq_d = -1;
        for (int g = 0; g < 2000 && !(l == 7 && d == 99); g++) step();
        lyc = 8'd10; stat_sel = 4'b1000;
        for (int g = 0; g < 5000 && !(l == 11 && d == 0); g++) begin
            step();
            if (l == 10 && coincidence) coin_cnt++;
            if (stat_irq) begin irq_cnt++; irq_l = int'(ly); irq_d = d; end
        end
        checks++; if (coin_cnt !== 456) begin errors++; $display("FAIL coin_line10 got %0d cycles want 456", coin_cnt); end
        checks++; if (irq_cnt !== 1 || irq_l !== 10 || irq_d !== 0) begin
            errors++; $display("FAIL lyc_irq got %0d pulses last at ly %0d dot %0d want 1 at ly 10 dot 0", irq_cnt, irq_l, irq_d);
        end
        checks++; if (coincidence !== 1'b0) begin errors++; $display("FAIL coin_line11 got %b want 0", coincidence); end
        check_bad("lyc_coincidence");
    endtask

    task automatic test_full_frame();
        int prev_ly;
        bit wrapped;
        prev_ly = -1; wrapped = 1'b0;
        vb_l = -1; vb_d = -1; vb_mode = -1;
        for (int g = 0; g < 80000 && !wrapped; g++) begin
            prev_ly = int'(ly);
            step();
            wrapped = (l == 0 && d == 0);
        end
        checks++; if (!wrapped) begin errors++; $display("FAIL frame_wrap_timeout got no wrap want wrap"); end
        checks++; if (prev_ly !== 153 || ly !== 8'd0 || frame_start !== 1'b1) begin
            errors++; $display("FAIL frame_wrap got %0d->%0d fs %b want 153->0 fs 1", prev_ly, ly, frame_start);
        end
        checks++; if (n_draw !== 144) begin errors++; $display("FAIL frame_drawlines got %0d want 144", n_draw); end
        checks++; if (n_vb !== 1 || vb_l !== 144 || vb_d !== 0 || vb_mode !== 1) begin
            errors++; $display("FAIL vblank_irq got %0d at ly %0d dot %0d mode %0d want 1 at 144/0 mode 1", n_vb, vb_l, vb_d, vb_mode);
        end
        checks++; if (n_m1 !== 4560) begin errors++; $display("FAIL vblank_mode_cycles got %0d want 4560", n_m1); end
        checks++; if (n_fs !== 2) begin errors++; $display("FAIL frame_start_count got %0d want 2", n_fs); end
        check_bad("full_frame");
    endtask

    task automatic test_lcd_off();
        int early_draw;
        early_draw = 0;
        for (int g = 0; g < 2000 && !(l == 1 && d == 150); g++) step();
        lcd_on = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (ly !== 8'd0 || mode !== 2'd0 || vram_locked !== 1'b0 || oam_locked !== 1'b0) begin
            errors++; $display("FAIL lcd_off got ly %0d mode %0d locks %b%b want 0 0 00", ly, mode, vram_locked, oam_locked);
        end
        repeat (3) @(posedge clk); #1;
        checks++;
        if (ly !== 8'd0 || mode !== 2'd0 || {drawline, frame_start, vblank_irq, stat_irq} !== 4'd0) begin
            errors++; $display("FAIL lcd_off_hold got ly %0d mode %0d pulses %b want 0 0 0000", ly, mode,
                               {drawline, frame_start, vblank_irq, stat_irq});
        end
        lcd_on = 1'b1; dot_en = 1'b0;
        repeat (2) @(posedge clk); #1;
        checks++; if (mode !== 2'd0 || frame_start !== 1'b0) begin
            errors++; $display("FAIL lcd_on_no_dot got mode %0d fs %b want 0 0", mode, frame_start);
        end
        started = 1'b0; prev_line = 1'b0;
        step();
        checks++; if (frame_start !== 1'b1 || mode !== 2'd2 || ly !== 8'd0) begin
            errors++; $display("FAIL lcd_on_start got fs %b mode %0d ly %0d want 1 2 0", frame_start, mode, ly);
        end
        for (int i = 1; i < 80; i++) begin
            step();
            early_draw += int'(drawline);
        end
        step();
        checks++; if (early_draw !== 0 || drawline !== 1'b1) begin
            errors++; $display("FAIL lcd_on_drawline got early %0d at80 %b want 0 1", early_draw, drawline);
        end
        check_bad("lcd_off");
    endtask

    task automatic test_half_duty();
        int cyc, t1, t2, draw_cyc;
        logic [7:0] last_ly;
        cyc = 0; t1 = -1; t2 = -1; draw_cyc = 0; last_ly = ly;
        for (int g = 0; g < 4000 && t2 < 0; g++) begin
            if (g % 2 == 0) step(); else idle();
            cyc++;
            if (ly == 8'd1 && drawline) draw_cyc++;
            if (ly !== last_ly) begin
                if (ly == 8'd1) t1 = cyc;
                if (ly == 8'd2) t2 = cyc;
            end
            last_ly = ly;
        end
        checks++; if (t2 - t1 !== 912 || t1 < 0) begin
            errors++; $display("FAIL half_duty_line got %0d clk want 912", t2 - t1);
        end
        checks++; if (draw_cyc !== 1) begin errors++; $display("FAIL half_duty_pulse_width got %0d want 1", draw_cyc); end
        check_bad("half_duty");
    endtask

    task automatic test_reset_mid();
        for (int g = 0; g < 1000 && d != 100; g++) step();
        checks++; if (vram_locked !== 1'b1) begin errors++; $display("FAIL mode3_vram_lock got %b want 1", vram_locked); end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({ly, mode, coincidence, drawline, frame_start, vblank_irq, stat_irq, vram_locked, oam_locked} !== 16'd0) begin
            errors++; $display("FAIL reset_mid got %h want 0000",
                {ly, mode, coincidence, drawline, frame_start, vblank_irq, stat_irq, vram_locked, oam_locked});
        end
        reset = 1'b0;
        started = 1'b0; prev_line = 1'b0;
        step();
        checks++; if (frame_start !== 1'b1 || mode !== 2'd2) begin
            errors++; $display("FAIL reset_restart got fs %b mode %0d want 1 2", frame_start, mode);
        end
        check_bad("reset_mid");
    endtask

    initial begin
        bad = 0; first_bad = ""; started = 1'b0; prev_line = 1'b0; d = 0; l = 0;
        test_reset();
        test_first_line();
        test_stat_blocking();
        test_lyc_coincidence();
        test_full_frame();
        test_lcd_off();
        test_half_duty();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
